ft601_ep_fifo_buf: RTL
======================

Name: ft601_ep_fifo_buf

Overview:
- Shared-memory, four-endpoint FIFO buffer. It sits directly downstream of the FT601 bus controller and collects OUT-direction (host-to-FPGA) words per endpoint for user logic.
- One RAM of 2^T_MSZ words is split into CNT_CHANNLS equal regions of 2^EPm_MSZ words. Bases are 'h000/'h400/'h800/'hC00 in the default build.
- Each endpoint has its own write/read pointers and full/empty flags. Status is exported on an 8-bit status bus.

Parameters:
- WIDTH_DATA, 32, data word width (package value)
- CNT_BE, 4, byte enables stored alongside each word
- CNT_CHANNLS, 4, number of endpoints
- EPm_MSZ, 10 (12 when MEM_64K), log2 of words per endpoint region
- T_MSZ, 12 (14 when MEM_64K), log2 of total RAM words; must equal EPm_MSZ + CNT_CODE_NUM_CHNLS

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- wr_vld  in  1  write request from the FT601 controller
- wr_ep  in  CNT_CODE_NUM_CHNLS+1 (3)  endpoint number, valid values 1..4 (EP1_NUM..EP4_NUM)
- wr_data  in  WIDTH_DATA  write word
- wr_be  in  CNT_BE  byte enables for the word
- wr_rdy  out  1  combinational: wr_ep is valid and that endpoint is not full
- rd_req  in  1  read request from user logic
- rd_ep  in  3  endpoint number for the read, 1..4
- rd_data  out  WIDTH_DATA  read word
- rd_be  out  CNT_BE  byte enables of the read word
- rd_vld  out  1  rd_data/rd_be valid for exactly this cycle
- ep_flush  in  CNT_CHANNLS  per-endpoint pointer clear; bit0 = EP1
- status  out  WIDTH_BUS_STATUS  {ep_empty[3:0], ep_full[3:0]}, registered
- ep_err  out  1  sticky flag for an access to an invalid endpoint

Behaviour:
- **Endpoint mapping.** Index = ep − 1. RAM address = {idx[1:0], ptr[EPm_MSZ-1:0]}.
- **Pointers.** Per endpoint, wptr and rptr are EPm_MSZ+1 bits and wrap naturally.
  - empty when wptr == rptr.
  - full when the MSBs differ and the low bits are equal.
- **Write.** Accepted when wr_vld && wr_rdy. The word and BE are written to RAM at wptr, and wptr increments in the same clock.
  - wr_vld while not ready: no effect; the controller holds the data.
- **Read.** Accepted when rd_req, rd_ep is valid, and that endpoint is not empty. rptr increments.
  - rd_vld, rd_data and rd_be appear exactly 1 cycle later (registered RAM output).
  - A rejected read gives rd_vld = 0 the next cycle.
- **Flags.** status reflects pointer state after the edge, one register stage after the pointer update.
  - wr_rdy and read acceptance use the live pointers, not the status register. This means a write to an empty endpoint is readable on the next cycle.
- **Simultaneous write and read, same endpoint.** Both are performed and the occupancy is unchanged.
  - When full, the read frees a slot, but wr_rdy is still 0 that cycle. The write waits one cycle.
- **Simultaneous write and read, different endpoints.** Fully independent.
- **Flush.** ep_flush[i] sets wptr = rptr = 0 for endpoint i.
  - It has priority over any same-cycle write or read of endpoint i; those are dropped, wr_rdy is forced to 0 and rd_vld is 0.
  - Stale RAM contents are not cleared.
- **Invalid endpoint (0, 5, 6, 7).** wr_rdy = 0 and the read is ignored.
  - ep_err sets when wr_vld or rd_req arrives with an invalid ep. It stays set until rst.
- **Reset (any cycle, including mid-burst).** All pointers = 0, status = 8'hF0, rd_vld = 0, rd_data = 0, rd_be = 0, ep_err = 0.
  - A read accepted on the cycle before reset does not produce rd_vld after reset.
  - RAM contents are undefined.

Optional Feature:
- Macro: FT601_EP_LEVEL_EN.
- Defined: adds output ep_level, CNT_CHANNLS*(EPm_MSZ+1) bits, with field i = wptr_i − rptr_i.
  - Registered, same timing as status.
  - Resets to 0 and is cleared on flush.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- **Shared package pkg_ft601_ctrl_defines** gets the following additions:
  - typedef ty_ep_idx (logic [CNT_CODE_NUM_CHNLS-1:0])
  - typedef ty_ep_ptr (logic [EPm_MSZ:0])
  - function f_ep_valid(ep): returns 1 for ep in 1..CNT_CHANNLS
  - function f_ep_to_idx(ep): returns ep − 1
  - status bit positions: EMPTY_LSB = 4, FULL_LSB = 0
- **One sub-module, ft601_ep_ram.**
  - Simple dual-port RAM, 2^T_MSZ × (WIDTH_DATA+CNT_BE).
  - One write port and one registered read port, 1-cycle latency, no reset on the array.

Test Plan:
- **Reset and basic round trip.** Release rst; write EP2 data 'hDEADBEEF, be 4'hF; on the next cycle read EP2 → rd_vld 1 cycle later with 'hDEADBEEF/4'hF; status 8'hF0 → 8'hD0 → 8'hF0.
- **Fill to full.** Write 1024 words to EP1 → status[0] = 1 and wr_rdy = 0. A further wr_vld leaves pointers unchanged. Reading 1024 words returns values 0..1023 in order, then EP1 shows empty.
- **Concurrent access at full.** With EP3 full, assert rd_req and wr_vld on EP3 together → read accepted, write stalls one cycle then is accepted; EP3 ends full and its level stays 1024.
- **Flush priority.** EP4 holds 5 words; same cycle as ep_flush = 4'b1000, assert a write and a read on EP4 → both dropped, rd_vld = 0, status[7] = 1. EP1–EP3 are unaffected.
- **Invalid endpoint.** wr_vld with wr_ep = 0, then rd_req with rd_ep = 5 → wr_rdy = 0, no rd_vld, ep_err = 1 until rst.
- **Reset mid-burst.** Assert rst during an EP2 read burst → no rd_vld after reset, status = 8'hF0, ep_level all 0 (with FT601_EP_LEVEL_EN).

Source files
------------

// File: rtl/ft601_ep_fifo_buf_pkg.sv
// ---------------------------------------------------------------------------
// pkg_ft601_ctrl_defines
// Shared definitions for the FT601 controller slice: data/BE widths, endpoint
// count and numbering, per-endpoint RAM sizing, status bit positions, and
// helpers that validate an endpoint number and turn it into a RAM region index.
// Build options:
//   MEM_64K - enlarges each endpoint region from 2^10 to 2^12 words.
// ---------------------------------------------------------------------------
package pkg_ft601_ctrl_defines;

  localparam int WIDTH_DATA         = 32;
  localparam int CNT_BE             = 4;
  localparam int CNT_CHANNLS        = 4;
  localparam int CNT_CODE_NUM_CHNLS = 2;

`ifdef MEM_64K
  localparam int EPm_MSZ = 12;
`else
  localparam int EPm_MSZ = 10;
`endif

  // Each endpoint owns one equal slice of the shared RAM. The endpoint index
  // forms the top address bits.
  localparam int T_MSZ            = EPm_MSZ + CNT_CODE_NUM_CHNLS;
  localparam int WIDTH_BUS_STATUS = 8;
  localparam int WIDTH_EP         = CNT_CODE_NUM_CHNLS + 1;
  localparam int WIDTH_RAM        = WIDTH_DATA + CNT_BE;

  localparam logic [WIDTH_EP-1:0] EP1_NUM = 3'd1;
  localparam logic [WIDTH_EP-1:0] EP2_NUM = 3'd2;
  localparam logic [WIDTH_EP-1:0] EP3_NUM = 3'd3;
  localparam logic [WIDTH_EP-1:0] EP4_NUM = 3'd4;

  localparam int EMPTY_LSB = 4;
  localparam int FULL_LSB  = 0;

  typedef logic [CNT_CODE_NUM_CHNLS-1:0] ty_ep_idx;
  typedef logic [EPm_MSZ:0]              ty_ep_ptr;
  typedef logic [WIDTH_EP-1:0]           ty_ep_num;

  function automatic logic f_ep_valid(input ty_ep_num ep);
    return (ep >= EP1_NUM) && (ep <= EP4_NUM);
  endfunction

  // An invalid endpoint number still maps to some index. Callers gate the
  // result with f_ep_valid.
  function automatic ty_ep_idx f_ep_to_idx(input ty_ep_num ep);
    ty_ep_num diff;
    diff = ep - EP1_NUM;
    return diff[CNT_CODE_NUM_CHNLS-1:0];
  endfunction

endpackage

// File: rtl/ft601_ep_fifo_buf_ram.sv
// ---------------------------------------------------------------------------
// ft601_ep_ram
// Simple dual-port RAM shared by all endpoints. It has one write port and one
// registered read port with a 1-cycle latency. The array has no reset.
// Ports:
//   clk   - clock
//   we    - write enable;  waddr/wdata - write address and {data, be} word
//   re    - read enable;   raddr       - read address
//   rdata - registered read word; it updates only on a cycle with re
// ---------------------------------------------------------------------------
module ft601_ep_ram
  import pkg_ft601_ctrl_defines::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [T_MSZ-1:0]     waddr,
  input  logic [WIDTH_RAM-1:0] wdata,
  input  logic                 re,
  input  logic [T_MSZ-1:0]     raddr,
  output logic [WIDTH_RAM-1:0] rdata
);

  logic [WIDTH_RAM-1:0] mem [0:(1 << T_MSZ)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ft601_ep_fifo_buf.sv
// ---------------------------------------------------------------------------
// ft601_ep_fifo_buf
// Four-endpoint OUT-direction FIFO buffer built on one shared RAM. Each
// endpoint has its own read and write pointers. These pointers are one bit
// wider than the region address so that full and empty can be told apart.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   wr_vld/wr_ep/wr_data/wr_be, wr_rdy - write side (from FT601 controller)
//   rd_req/rd_ep       - read request (from user logic)
//   rd_data/rd_be/rd_vld - read word, valid one cycle after acceptance
//   ep_flush           - per-endpoint pointer clear, bit0 = EP1
//   status             - registered {ep_empty[3:0], ep_full[3:0]}
//   ep_err             - sticky flag for an access to an invalid endpoint
//   ep_level           - per-endpoint occupancy (only with FT601_EP_LEVEL_EN)
// Build options:
//   FT601_EP_LEVEL_EN - adds the registered ep_level output.
// ---------------------------------------------------------------------------
module ft601_ep_fifo_buf
  import pkg_ft601_ctrl_defines::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_vld,
  input  logic [WIDTH_EP-1:0]         wr_ep,
  input  logic [WIDTH_DATA-1:0]       wr_data,
  input  logic [CNT_BE-1:0]           wr_be,
  output logic                        wr_rdy,
  input  logic                        rd_req,
  input  logic [WIDTH_EP-1:0]         rd_ep,
  output logic [WIDTH_DATA-1:0]       rd_data,
  output logic [CNT_BE-1:0]           rd_be,
  output logic                        rd_vld,
  input  logic [CNT_CHANNLS-1:0]      ep_flush,
  output logic [WIDTH_BUS_STATUS-1:0] status,
  output logic                        ep_err
`ifdef FT601_EP_LEVEL_EN
  ,
  output logic [CNT_CHANNLS*(EPm_MSZ+1)-1:0] ep_level
`endif
);

  ty_ep_ptr wptr [CNT_CHANNLS];
  ty_ep_ptr rptr [CNT_CHANNLS];

  logic [CNT_CHANNLS-1:0] ep_empty;
  logic [CNT_CHANNLS-1:0] ep_full;

  ty_ep_idx wr_idx;
  ty_ep_idx rd_idx;
  logic     wr_ok;
  logic     rd_ok;
  logic     wr_acc;
  logic     rd_acc;

  logic [WIDTH_RAM-1:0] ram_rdata;
  logic [T_MSZ-1:0]     ram_waddr;
  logic [T_MSZ-1:0]     ram_raddr;

  always_comb begin
    ep_empty = '0;
    ep_full  = '0;
    for (int i = 0; i < CNT_CHANNLS; i++) begin
      ep_empty[i] = (wptr[i] == rptr[i]);
      ep_full[i]  = (wptr[i][EPm_MSZ] != rptr[i][EPm_MSZ]) &&
                    (wptr[i][EPm_MSZ-1:0] == rptr[i][EPm_MSZ-1:0]);
    end
  end

  // Acceptance uses the live pointers. A same-cycle flush takes priority
  // over both a write and a read on its endpoint. A read never targets the
  // slot being written in the same cycle: a non-empty endpoint has rptr != wptr,
  // and a full endpoint takes no write.
  always_comb begin
    wr_ok  = f_ep_valid(wr_ep);
    rd_ok  = f_ep_valid(rd_ep);
    wr_idx = f_ep_to_idx(wr_ep);
    rd_idx = f_ep_to_idx(rd_ep);
    wr_rdy = wr_ok && !ep_full[wr_idx] && !ep_flush[wr_idx];
    wr_acc = wr_vld && wr_rdy;
    rd_acc = rd_req && rd_ok && !ep_empty[rd_idx] && !ep_flush[rd_idx];
    ram_waddr = {wr_idx, wptr[wr_idx][EPm_MSZ-1:0]};
    ram_raddr = {rd_idx, rptr[rd_idx][EPm_MSZ-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CNT_CHANNLS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CNT_CHANNLS; i++) begin
        if (ep_flush[i]) begin
          wptr[i] <= '0;
          rptr[i] <= '0;
        end else begin
          if (wr_acc && (wr_idx == ty_ep_idx'(i))) wptr[i] <= wptr[i] + ty_ep_ptr'(1);
          if (rd_acc && (rd_idx == ty_ep_idx'(i))) rptr[i] <= rptr[i] + ty_ep_ptr'(1);
        end
      end
    end
  end

  ft601_ep_ram u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata ({wr_data, wr_be}),
    .re    (rd_acc),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset. Gating it with rd_vld keeps
  // rd_data/rd_be at zero after reset and between reads.
  always_ff @(posedge clk) begin
    if (rst) rd_vld <= 1'b0;
    else     rd_vld <= rd_acc;
  end

  assign rd_data = rd_vld ? ram_rdata[WIDTH_RAM-1:CNT_BE] : '0;
  assign rd_be   = rd_vld ? ram_rdata[CNT_BE-1:0]         : '0;

  // Flags are sampled from the pointer registers, one stage behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
      status[EMPTY_LSB +: CNT_CHANNLS] <= '1;
    end else begin
      status[EMPTY_LSB +: CNT_CHANNLS] <= ep_empty;
      status[FULL_LSB +: CNT_CHANNLS]  <= ep_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ep_err <= 1'b0;
    else if ((wr_vld && !wr_ok) || (rd_req && !rd_ok)) ep_err <= 1'b1;
  end

`ifdef FT601_EP_LEVEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ep_level <= '0;
    end else begin
      for (int i = 0; i < CNT_CHANNLS; i++) begin
        ep_level[i*(EPm_MSZ+1) +: (EPm_MSZ+1)] <= wptr[i] - rptr[i];
      end
    end
  end
`endif

endmodule
